shift_reg_univ: RTL

Parametrised universal shift register for the shift-register family: WIDTH-bit storage with hold, shift-left, shift-right and parallel load, plus a burst engine that performs a programmed number of shifts under a start/busy/done handshake. It is intended as the general replacement for fixed-width serial-in shifters in serialiser, deserialiser and scan-style datapaths, where a controller issues a burst and waits for done.

---
 rtl/shift_reg_univ.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/shift_reg_univ.sv
`default_nettype none
// ============================================================================
// Module      : shift_reg_univ
// Description : WIDTH-bit universal shift register (hold / shift left /
//               shift right / parallel load) with a start/busy/done burst
//               engine that performs a programmed number of shifts.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_reg_univ #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sin_lsb,
    input  logic             sin_msb,
    input  logic [WIDTH-1:0] pdata,
    input  logic             start,
    input  logic [CW-1:0]    len,
    input  logic             dir,
    output logic [WIDTH-1:0] q,
    output logic             sout_msb,
    output logic             sout_lsb,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUSY = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    localparam logic [1:0] c_MODE_HOLD  = 2'b00;
    localparam logic [1:0] c_MODE_LEFT  = 2'b01;
    localparam logic [1:0] c_MODE_RIGHT = 2'b10;
    localparam logic [1:0] c_MODE_LOAD  = 2'b11;

    localparam logic [CW-1:0] c_WIDTH_CW = CW'(WIDTH);
    localparam logic [CW-1:0] c_ONE_CW   = CW'(1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_nxt;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_nxt;
    logic             r_dir;
    logic             w_dir_nxt;
    logic [CW-1:0]    w_len_sat;
    logic [WIDTH-1:0] w_shl;
    logic [WIDTH-1:0] w_shr;
    logic             w_busy;
    logic             w_done;
    logic             w_accept;

    assign w_len_sat = (len > c_WIDTH_CW) ? c_WIDTH_CW : len;
    assign w_shl     = {r_q[WIDTH-2:0], sin_lsb};
    assign w_shr     = {sin_msb, r_q[WIDTH-1:1]};

    // The done cycle behaves as idle, which is what allows back-to-back bursts.
    assign w_accept  = start && (r_state != c_ST_BUSY);

    // ------------------------------------------------------------------------
    // Burst control FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clr) begin
            w_state_nxt = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_BUSY: begin
                    if (r_count == c_ONE_CW) begin
                        w_state_nxt = c_ST_DONE;
                    end else begin
                        w_state_nxt = c_ST_BUSY;
                    end
                end
                default: begin
                    if (start) begin
                        w_state_nxt = (w_len_sat == '0) ? c_ST_DONE : c_ST_BUSY;
                    end else begin
                        w_state_nxt = c_ST_IDLE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            c_ST_BUSY: w_busy = 1'b1;
            c_ST_DONE: w_done = 1'b1;
            default: begin
                w_busy = 1'b0;
                w_done = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: storage, remaining-shift counter, latched burst direction
    // ------------------------------------------------------------------------
    always_comb begin
        w_q_nxt     = r_q;
        w_count_nxt = r_count;
        w_dir_nxt   = r_dir;
        if (clr) begin
            w_q_nxt     = '0;
            w_count_nxt = '0;
        end else if (w_busy) begin
            w_q_nxt     = r_dir ? w_shr : w_shl;
            w_count_nxt = r_count - c_ONE_CW;
        end else if (w_accept) begin
            // q is deliberately left untouched on the accepting edge.
            w_dir_nxt   = dir;
            w_count_nxt = w_len_sat;
        end else if (en) begin
            case (mode)
                c_MODE_LEFT:  w_q_nxt = w_shl;
                c_MODE_RIGHT: w_q_nxt = w_shr;
                c_MODE_LOAD:  w_q_nxt = pdata;
                c_MODE_HOLD:  w_q_nxt = r_q;
                default:      w_q_nxt = r_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q     <= '0;
            r_count <= '0;
            r_dir   <= 1'b0;
        end else begin
            r_q     <= w_q_nxt;
            r_count <= w_count_nxt;
            r_dir   <= w_dir_nxt;
        end
    end

    assign q        = r_q;
    assign sout_msb = r_q[WIDTH-1];
    assign sout_lsb = r_q[0];
    assign busy     = w_busy;
    assign done     = w_done;

endmodule
`default_nettype wire
